// File: rtl/regist_pipe.sv
// ---------------------------------------------------------------------------
// regist_pipe
//
// Elastic pipeline register for the GF(2^163) digit-serial datapath. A
// WIDTH-bit word travels through DEPTH register stages under a valid/ready
// handshake. Stages advance independently, so bubbles collapse towards the
// output and a stalled downstream cell does not freeze the array upstream of
// the first occupied stage.
//
// Optional feature macro: REGIST_PIPE_FLUSH_EN
//   When defined, a 'flush' input is added. flush high at a clock edge
//   discards every held word. Data registers keep their contents and no
//   word is accepted during that cycle.
//
// Parameters:
//   WIDTH  data width in bits (1..256)
//   DEPTH  number of register stages (1..16)
//   CW     width of the occupancy count, derived from DEPTH
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_data    word offered by the upstream cell
//   in_valid   in_data is valid this cycle
//   in_ready   pipe accepts in_data this cycle (combinational)
//   out_data   contents of the last stage (registered)
//   out_valid  last stage holds a valid word (registered)
//   out_ready  downstream consumes out_data this cycle
//   count      number of valid stages, 0..DEPTH (registered)
//   flush      synchronous discard (REGIST_PIPE_FLUSH_EN only)
// ---------------------------------------------------------------------------
module regist_pipe #(
    parameter  int WIDTH = 15,
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    count
`ifdef REGIST_PIPE_FLUSH_EN
    ,
    input  logic             flush
`endif
);

    // -----------------------------------------------------------------------
    // Stage storage
    // -----------------------------------------------------------------------
    logic [WIDTH-1:0] data_reg  [DEPTH];
    logic [WIDTH-1:0] data_next [DEPTH];
    logic [DEPTH-1:0] valid_reg;
    logic [DEPTH-1:0] valid_next;
    logic [DEPTH-1:0] load;
    logic [DEPTH-1:0] adv;
    logic [CW-1:0]    count_reg;
    logic [CW-1:0]    count_next;

    logic             flush_act;
    logic             in_fire;
    logic             out_fire;

`ifdef REGIST_PIPE_FLUSH_EN
    assign flush_act = flush;
`else
    assign flush_act = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Advance chain. A stage moves its word on when it is valid and the
    // stage after it is either empty or itself moving on. Evaluated from the
    // output end backwards so out_ready ripples to in_ready in one cycle.
    // -----------------------------------------------------------------------
    always_comb begin
        adv = '0;
        adv[DEPTH-1] = valid_reg[DEPTH-1] & out_ready;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            adv[i] = valid_reg[i] & (~valid_reg[i+1] | adv[i+1]);
        end
    end

    // Flush blocks acceptance so the discarded cycle cannot swallow a word.
    assign in_ready = (~valid_reg[0] | adv[0]) & ~flush_act;
    assign in_fire  = in_valid & in_ready;
    // An output transfer during a flush cycle is discarded along with the
    // rest; count is cleared outright rather than decremented.
    assign out_fire = adv[DEPTH-1] & ~flush_act;

    // -----------------------------------------------------------------------
    // Per-stage next-state. Stage 0 loads from the input port, every other
    // stage loads from its predecessor when that predecessor advances.
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign load[gi]      = in_fire;
                assign data_next[gi] = load[gi] ? in_data : data_reg[gi];
            end else begin : g_body
                assign load[gi]      = adv[gi-1] & ~flush_act;
                assign data_next[gi] = load[gi] ? data_reg[gi-1] : data_reg[gi];
            end

            // Loading wins over emptying: a stage that hands its word on
            // and receives a new one in the same cycle stays valid.
            always_comb begin
                valid_next[gi] = valid_reg[gi];
                if (flush_act) begin
                    valid_next[gi] = 1'b0;
                end else if (load[gi]) begin
                    valid_next[gi] = 1'b1;
                end else if (adv[gi]) begin
                    valid_next[gi] = 1'b0;
                end
            end
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Occupancy counter: tracks the popcount of valid_reg incrementally.
    // -----------------------------------------------------------------------
    always_comb begin
        count_next = count_reg;
        if (flush_act) begin
            count_next = '0;
        end else begin
            unique case ({in_fire, out_fire})
                2'b10:   count_next = count_reg + CW'(1);
                2'b01:   count_next = count_reg - CW'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_reg <= '0;
            count_reg <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_reg[i] <= '0;
            end
        end else begin
            valid_reg <= valid_next;
            count_reg <= count_next;
            for (int i = 0; i < DEPTH; i++) begin
                data_reg[i] <= data_next[i];
            end
        end
    end

    assign out_data  = data_reg[DEPTH-1];
    assign out_valid = valid_reg[DEPTH-1];
    assign count     = count_reg;

endmodule

// File: tb/tb_regist_pipe.sv
// ---------------------------------------------------------------------------
// tb_regist_pipe
//
// Directed testbench for regist_pipe at WIDTH=15, DEPTH=4. Inputs change one
// time unit after the rising edge; outputs are sampled there as well, well
// away from the active edge. Expected values are worked out by hand from the
// pipe's timing (word accepted at edge k is valid after edge k+3).
// ---------------------------------------------------------------------------
module tb_regist_pipe;

    localparam int WIDTH = 15;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [CW-1:0]    count;
`ifdef REGIST_PIPE_FLUSH_EN
    logic             flush;
`endif

    int errors = 0;
    int checks = 0;

    logic [WIDTH-1:0] sb[$];

    regist_pipe #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .count    (count)
`ifdef REGIST_PIPE_FLUSH_EN
        ,
        .flush    (flush)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One cycle of handshake with a scoreboard: accepted words are queued,
    // delivered words must come out in queue order.
    task automatic xfer(input logic v, input logic [WIDTH-1:0] d, input logic r);
        logic [WIDTH-1:0] exp_w;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        #1;
        if (in_valid && in_ready) begin
            sb.push_back(d);
            $display("xfer in  data=0x%04h", d);
        end
        if (out_valid && out_ready) begin
            if (sb.size() == 0) exp_w = 'x;
            else exp_w = sb.pop_front();
            $display("xfer out data=0x%04h", out_data);
            check("sb_order", 32'(out_data), 32'(exp_w));
        end
        step();
    endtask

    initial begin
        int exp_cnt[6];
        exp_cnt = '{1, 1, 1, 2, 2, 2};

        rst       = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
`ifdef REGIST_PIPE_FLUSH_EN
        flush     = 1'b0;
`endif
        #2;
        // Reset state before any clock edge.
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_out_data",  32'(out_data),  32'(0));
        check("rst_count",     32'(count),     32'(0));
        check("rst_in_ready",  32'(in_ready),  32'(1));
        step();
        step();
        rst = 1'b0;

        // ---------------- Latency / throughput ----------------
        out_ready = 1'b1;
        for (int j = 0; j < 16; j++) begin
            in_valid = 1'b1;
            in_data  = WIDTH'(j + 1);
            step();
            check("tp_in_ready",  32'(in_ready),  32'(1));
            check("tp_count",     32'(count),     (j < 3) ? 32'(j + 1) : 32'(4));
            check("tp_out_valid", 32'(out_valid), 32'(j >= 3));
            if (j >= 3) check("tp_out_data", 32'(out_data), 32'(j - 2));
        end
        in_valid = 1'b0;
        for (int j = 16; j < 20; j++) begin
            step();
            check("drain_count",     32'(count),     32'(19 - j));
            check("drain_out_valid", 32'(out_valid), 32'(j < 19));
            if (j < 19) check("drain_out_data", 32'(out_data), 32'(j - 2));
        end

        // ---------------- Back-pressure ----------------
        out_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1;
            in_data  = WIDTH'(32'h100 + k);
            #1;
            check("bp_in_ready_pre", 32'(in_ready), 32'(k < 4));
            step();
            check("bp_count",        32'(count),    (k < 4) ? 32'(k + 1) : 32'(4));
            check("bp_in_ready",     32'(in_ready), 32'(k < 3));
        end
        in_valid = 1'b0;
        #1;
        check("bp_full_valid", 32'(out_valid), 32'(1));
        check("bp_full_data",  32'(out_data),  32'h100);
        out_ready = 1'b1;
        #1;
        check("bp_ready_same_cycle", 32'(in_ready), 32'(1));
        for (int m = 1; m <= 4; m++) begin
            step();
            check("bp_rel_count", 32'(count),     32'(4 - m));
            check("bp_rel_valid", 32'(out_valid), 32'(m < 4));
            if (m < 4) check("bp_rel_data", 32'(out_data), 32'(32'h100 + m));
        end

        // ---------------- Bubble collapse ----------------
        out_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            in_valid = (c == 0) || (c == 3);
            in_data  = (c == 0) ? WIDTH'(32'h2AA) : WIDTH'(32'h155);
            step();
            check("bub_count", 32'(count), 32'(exp_cnt[c]));
            if (c == 2) check("bub_latency_valid", 32'(out_valid), 32'(0));
        end
        in_valid = 1'b0;
        check("bub_packed_valid", 32'(out_valid), 32'(1));
        check("bub_packed_data",  32'(out_data),  32'h2AA);
        out_ready = 1'b1;
        step();
        check("bub_second_data",  32'(out_data),  32'h155);
        check("bub_second_count", 32'(count),     32'(1));
        step();
        check("bub_empty_valid",  32'(out_valid), 32'(0));
        check("bub_empty_count",  32'(count),     32'(0));

        // ---------------- Pass-through when full ----------------
        for (int i = 0; i < 4; i++) xfer(1'b1, WIDTH'(32'h300 + i), 1'b0);
        check("pt_fill_count", 32'(count), 32'(4));
        for (int i = 0; i < 10; i++) begin
            xfer(1'b1, WIDTH'(32'h304 + i), 1'b1);
            check("pt_count", 32'(count), 32'(4));
        end
        for (int i = 0; i < 4; i++) xfer(1'b0, '0, 1'b1);
        check("pt_drain_count", 32'(count), 32'(0));
        check("pt_sb_empty",    32'(sb.size()), 32'(0));

        // ---------------- Asynchronous reset mid-stream ----------------
        for (int i = 0; i < 3; i++) xfer(1'b1, WIDTH'(32'h7A0 + i), 1'b0);
        xfer(1'b0, '0, 1'b0);
        check("mr_count_pre", 32'(count),    32'(3));
        check("mr_data_pre",  32'(out_data), 32'h7A0);
        #3;
        rst = 1'b1;
        #1;
        check("mr_out_valid", 32'(out_valid), 32'(0));
        check("mr_out_data",  32'(out_data),  32'(0));
        check("mr_count",     32'(count),     32'(0));
        check("mr_in_ready",  32'(in_ready),  32'(1));
        step();
        rst = 1'b0;
        sb.delete();
        xfer(1'b1, WIDTH'(32'h0AB), 1'b0);
        check("mr_first_count", 32'(count), 32'(1));
        for (int i = 0; i < 4; i++) xfer(1'b0, '0, 1'b1);
        check("mr_drain_count", 32'(count), 32'(0));
        check("mr_sb_empty",    32'(sb.size()), 32'(0));

`ifdef REGIST_PIPE_FLUSH_EN
        // ---------------- Flush ----------------
        for (int i = 0; i < 3; i++) xfer(1'b1, WIDTH'(32'h050 + i), 1'b0);
        check("fl_count_pre", 32'(count), 32'(3));
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = WIDTH'(32'h666);
        #1;
        check("fl_in_ready", 32'(in_ready), 32'(0));
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl_count",     32'(count),     32'(0));
        check("fl_out_valid", 32'(out_valid), 32'(0));
        step();
        check("fl_count_after", 32'(count), 32'(0));
        sb.delete();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
